// File: rtl/ringosc_meas_pkg.sv
// Shared types, default widths and the saturating increment used by the
// ring-oscillator frequency counter.
package ringosc_meas_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } meas_state_e;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_GATE_W = 16;

    // Width-agnostic: callers zero-extend into 64 bits and truncate the result.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] top;
        top = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (val >= top) ? top : val + 64'd1;
    endfunction

endpackage

// File: rtl/ringosc_edge_sync.sv
// Two-flop synchronizer for the asynchronous oscillator tap plus a delay
// flop, producing a one-cycle rise strobe in the clk domain.
module ringosc_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic osc_in,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= osc_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/ringosc_freq_counter.sv
// Gated rising-edge counter for a ring-oscillator tap, with latched result.
// Optional running min/max of results enabled by RINGOSC_MEAS_MINMAX_EN.
module ringosc_freq_counter
    import ringosc_meas_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int GATE_W = DEF_GATE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              osc_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
`ifdef RINGOSC_MEAS_MINMAX_EN
    ,
    input  logic              clear_minmax,
    output logic [CNT_W-1:0]  count_min,
    output logic [CNT_W-1:0]  count_max
`endif
);

    logic              osc_rise;
    meas_state_e       state;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  acc;
    logic              sat;
    logic [CNT_W-1:0]  acc_inc;
    logic              acc_full;

    ringosc_edge_sync u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .osc_in (osc_in),
        .rise   (osc_rise)
    );

    assign acc_inc  = CNT_W'(sat_inc(64'(acc), CNT_W));
    assign acc_full = &acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            acc      <= '0;
            gate_cnt <= '0;
            sat      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= GATE;
                        busy     <= 1'b1;
                        gate_cnt <= (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
                        acc      <= '0;
                        sat      <= 1'b0;
                    end
                end
                GATE: begin
                    gate_cnt <= gate_cnt - GATE_W'(1);
                    if (gate_cnt == GATE_W'(1)) begin
                        // The rise seen on the closing edge still belongs to this window.
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        count    <= osc_rise ? acc_inc : acc;
                        overflow <= sat | (osc_rise & acc_full);
                    end else if (osc_rise) begin
                        acc <= acc_inc;
                        sat <= sat | acc_full;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RINGOSC_MEAS_MINMAX_EN
    // Tracks the result presented during the done cycle; clear and done
    // together restart both extremes from the new result.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_min <= '1;
            count_max <= '0;
        end else if (done) begin
            if (clear_minmax) begin
                count_min <= count;
                count_max <= count;
            end else begin
                count_min <= (count < count_min) ? count : count_min;
                count_max <= (count > count_max) ? count : count_max;
            end
        end else if (clear_minmax) begin
            count_min <= '1;
            count_max <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_ringosc_freq_counter.sv
// Directed bench for ringosc_freq_counter: a 16-bit and an 8-bit instance
// share stimulus; min/max checks compile only with RINGOSC_MEAS_MINMAX_EN.
module tb_ringosc_freq_counter;

    logic        clk;
    logic        rst;
    logic        osc_in;
    logic        start;
    logic [15:0] gate_cycles;
    logic        busy, done, overflow;
    logic [15:0] count;
    logic        busy8, done8, overflow8;
    logic [7:0]  count8;
`ifdef RINGOSC_MEAS_MINMAX_EN
    logic        clear_minmax;
    logic [15:0] count_min, count_max;
    logic [7:0]  count_min8, count_max8;
`endif

    int total = 0;
    int bad   = 0;
    int osc_half = 0;
    int osc_cnt  = 0;

    ringosc_freq_counter #(.CNT_W(16), .GATE_W(16)) dut (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start),
        .gate_cycles(gate_cycles), .busy(busy), .done(done),
        .count(count), .overflow(overflow)
`ifdef RINGOSC_MEAS_MINMAX_EN
        , .clear_minmax(clear_minmax), .count_min(count_min), .count_max(count_max)
`endif
    );

    ringosc_freq_counter #(.CNT_W(8), .GATE_W(16)) dut8 (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start),
        .gate_cycles(gate_cycles), .busy(busy8), .done(done8),
        .count(count8), .overflow(overflow8)
`ifdef RINGOSC_MEAS_MINMAX_EN
        , .clear_minmax(clear_minmax), .count_min(count_min8), .count_max(count_max8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator model: toggles every osc_half clk cycles, offset from the edge.
    always begin
        @(posedge clk);
        #3;
        if (osc_half != 0) begin
            osc_cnt = osc_cnt + 1;
            if (osc_cnt >= osc_half) begin
                osc_cnt = 0;
                osc_in = ~osc_in;
            end
        end
    end

    // Pulses start for one cycle; returns at the negedge just after T0.
    task automatic pulse_start(input logic [15:0] g);
        @(negedge clk);
        gate_cycles = g;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until done is seen (bounded).
    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < budget);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done); end
        total++; if (count !== 16'd0 || overflow !== 1'b0) begin bad++; $display("FAIL reset_result count=%0d ovf=%b want 0 0", count, overflow); end
        total++; if (count8 !== 8'd0 || busy8 !== 1'b0) begin bad++; $display("FAIL reset_8 count=%0d busy=%b want 0 0", count8, busy8); end
`ifdef RINGOSC_MEAS_MINMAX_EN
        total++; if (count_min !== 16'hFFFF || count_max !== 16'd0) begin bad++; $display("FAIL reset_minmax min=%h max=%h want ffff 0000", count_min, count_max); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        osc_half = 2;
        repeat (10) @(negedge clk);
        pulse_start(16'd100);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy busy=%b want 1", busy); end
        wait_done(200, n);
        total++; if (n !== 100) begin bad++; $display("FAIL basic_latency cycles=%0d want 100", n); end
        total++; if (count < 16'd24 || count > 16'd26) begin bad++; $display("FAIL basic_count count=%0d want 24..26", count); end
        total++; if (overflow !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_flags ovf=%b busy=%b want 0 0", overflow, busy); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width done=%b want 0", done); end
    endtask

    task automatic test_overflow();
        int n;
        osc_half = 1;
        repeat (4) @(negedge clk);
        pulse_start(16'd1000);
        wait_done(1100, n);
        total++; if (done8 !== 1'b1 || n !== 1000) begin bad++; $display("FAIL ovf_latency cycles=%0d done8=%b want 1000 1", n, done8); end
        total++; if (count8 !== 8'd255 || overflow8 !== 1'b1) begin bad++; $display("FAIL ovf_sat count8=%0d ovf8=%b want 255 1", count8, overflow8); end
        total++; if (count < 16'd499 || count > 16'd501 || overflow !== 1'b0) begin bad++; $display("FAIL ovf_wide count=%0d ovf=%b want 499..501 0", count, overflow); end
        pulse_start(16'd100);
        wait_done(200, n);
        total++; if (count8 < 8'd49 || count8 > 8'd51 || overflow8 !== 1'b0) begin bad++; $display("FAIL ovf_clear count8=%0d ovf8=%b want 49..51 0", count8, overflow8); end
    endtask

    task automatic test_zero_gate();
        osc_half = 0;
        repeat (6) @(negedge clk);
        pulse_start(16'd0);
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL zero_first busy=%b done=%b want 1 0", busy, done); end
        @(negedge clk);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_done done=%b busy=%b want 1 0", done, busy); end
        total++; if (count !== 16'd0 || overflow !== 1'b0) begin bad++; $display("FAIL zero_count count=%0d ovf=%b want 0 0", count, overflow); end
    endtask

    task automatic test_restart_ignored();
        int dones;
        int first;
        osc_half = 2;
        repeat (4) @(negedge clk);
        pulse_start(16'd100);
        dones = 0;
        first = -1;
        for (int c = 1; c <= 140; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 50);
            if (c == 20) gate_cycles = 16'd10;
            if (done === 1'b1) begin
                dones++;
                if (first < 0) first = c;
            end
        end
        start = 1'b0;
        total++; if (dones !== 1 || first !== 100) begin bad++; $display("FAIL restart_done dones=%0d at=%0d want 1 at 100", dones, first); end
        total++; if (count < 16'd24 || count > 16'd26) begin bad++; $display("FAIL restart_count count=%0d want 24..26", count); end
    endtask

    task automatic test_reset_abort();
        int dones;
        int n;
        pulse_start(16'd100);
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0 || count !== 16'd0 || done !== 1'b0) begin bad++; $display("FAIL abort_state busy=%b count=%0d done=%b want 0 0 0", busy, count, done); end
        dones = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done dones=%0d want 0", dones); end
        pulse_start(16'd100);
        wait_done(200, n);
        total++; if (n !== 100 || count < 16'd24 || count > 16'd26) begin bad++; $display("FAIL abort_remeasure cycles=%0d count=%0d want 100 24..26", n, count); end
    endtask

    task automatic test_back_to_back();
        int at [2];
        int k;
        osc_half = 2;
        @(negedge clk);
        gate_cycles = 16'd20;
        start = 1'b1;
        k = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done === 1'b1 && k < 2) begin
                at[k] = c;
                k++;
            end
        end
        start = 1'b0;
        repeat (30) @(negedge clk);
        total++; if (k !== 2 || at[1] - at[0] !== 21) begin bad++; $display("FAIL b2b_spacing dones=%0d gap=%0d want 2 21", k, (k == 2) ? at[1] - at[0] : -1); end
    endtask

`ifdef RINGOSC_MEAS_MINMAX_EN
    task automatic test_minmax();
        int n;
        int c;
        int exp_min, exp_max;
        logic [15:0] gates [3] = '{16'd100, 16'd200, 16'd40};
        int lo [3] = '{24, 49, 9};
        int hi [3] = '{26, 51, 11};
        osc_half = 2;
        @(negedge clk);
        clear_minmax = 1'b1;
        @(negedge clk);
        clear_minmax = 1'b0;
        total++; if (count_min !== 16'hFFFF || count_max !== 16'd0) begin bad++; $display("FAIL mm_clear min=%h max=%h want ffff 0000", count_min, count_max); end
        exp_min = 65535;
        exp_max = 0;
        for (int i = 0; i < 3; i++) begin
            pulse_start(gates[i]);
            wait_done(300, n);
            c = int'(count);
            total++; if (c < lo[i] || c > hi[i]) begin bad++; $display("FAIL mm_window%0d count=%0d want %0d..%0d", i, c, lo[i], hi[i]); end
            if (c < exp_min) exp_min = c;
            if (c > exp_max) exp_max = c;
            @(negedge clk);
        end
        total++; if (int'(count_min) !== exp_min || int'(count_max) !== exp_max) begin bad++; $display("FAIL mm_track min=%0d max=%0d want %0d %0d", count_min, count_max, exp_min, exp_max); end
        pulse_start(16'd120);
        wait_done(300, n);
        c = int'(count);
        clear_minmax = 1'b1;
        @(negedge clk);
        clear_minmax = 1'b0;
        total++; if (c < 29 || c > 31) begin bad++; $display("FAIL mm_last_count count=%0d want 29..31", c); end
        total++; if (int'(count_min) !== c || int'(count_max) !== c) begin bad++; $display("FAIL mm_clear_done min=%0d max=%0d want %0d %0d", count_min, count_max, c, c); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        osc_in = 1'b0;
        start = 1'b0;
        gate_cycles = 16'd0;
`ifdef RINGOSC_MEAS_MINMAX_EN
        clear_minmax = 1'b0;
`endif
        test_reset();
        test_basic();
        test_overflow();
        test_zero_gate();
        test_restart_ignored();
        test_reset_abort();
        test_back_to_back();
`ifdef RINGOSC_MEAS_MINMAX_EN
        test_minmax();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
